udm_bus_arbiter: RTL and testbench

- Shares one UDM-style slave bus (CSR block plus testmem) between two masters.
  - m0: the udm_memsplit debug master.
  - m1: a second master, e.g. a CPU data port.
- Selects one request per cycle and forwards it combinationally to the slave.
- Records the owner of every accepted read in an in-order ID FIFO.
- Routes each slave read response, registered, back to the owning master.

---
 rtl/udm_bus_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_udm_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/udm_bus_arbiter.sv
// udm_bus_arbiter: shares one UDM-style slave bus between two masters.
// m0 is the udm_memsplit debug master, m1 a second master (e.g. CPU data port).
// Requests are forwarded combinationally. Read owners are tracked in an in-order
// ID FIFO, and read responses are steered back, registered, to the owning master.
// Optional feature: define UDM_ARB_RR_EN for round-robin arbitration instead of
// fixed m0 priority.

module udm_bus_arbiter #(
   parameter int OUTST_DEPTH = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,

   input  logic                  m0_req_i,
   input  logic                  m0_we_i,
   input  logic [ADDR_W-1:0]     m0_addr_bi,
   input  logic [DATA_W/8-1:0]   m0_be_bi,
   input  logic [DATA_W-1:0]     m0_wdata_bi,
   output logic                  m0_ack_o,
   output logic                  m0_resp_o,
   output logic [DATA_W-1:0]     m0_rdata_bo,

   input  logic                  m1_req_i,
   input  logic                  m1_we_i,
   input  logic [ADDR_W-1:0]     m1_addr_bi,
   input  logic [DATA_W/8-1:0]   m1_be_bi,
   input  logic [DATA_W-1:0]     m1_wdata_bi,
   output logic                  m1_ack_o,
   output logic                  m1_resp_o,
   output logic [DATA_W-1:0]     m1_rdata_bo,

   output logic                  s_req_o,
   output logic                  s_we_o,
   output logic [ADDR_W-1:0]     s_addr_bo,
   output logic [DATA_W/8-1:0]   s_be_bo,
   output logic [DATA_W-1:0]     s_wdata_bo,
   input  logic                  s_ack_i,
   input  logic                  s_resp_i,
   input  logic [DATA_W-1:0]     s_rdata_bi,

   output logic                  err_o
);

   localparam int PTR_W = $clog2(OUTST_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTST_DEPTH);

   // Arbitration and handshake signals
   logic sel_m1;
   logic sel_req;
   logic blk;
   logic fifo_full;
   logic fifo_empty;
   logic push;
   logic pop;
   logic spurious;
   logic head_id;

   // ID FIFO state: one bit per entry (0 = m0, 1 = m1)
   logic [OUTST_DEPTH-1:0] id_mem_q, id_mem_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;

   // Registered response path and sticky error
   logic              m0_resp_q, m0_resp_d;
   logic              m1_resp_q, m1_resp_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
   logic              err_q, err_d;

`ifdef UDM_ARB_RR_EN
   // Last-grant register: 1 means m1 was the last master accepted
   logic last_q, last_d;

   // Round-robin choice: on contention the master that did not win last time goes
   always_comb begin
      sel_m1 = m1_req_i;
      if (m0_req_i && m1_req_i) begin
         sel_m1 = ~last_q;
      end
   end

   // Rotate only when a transfer is actually accepted, so a stalled grant holds
   always_comb begin
      last_d = last_q;
      if (s_req_o && s_ack_i) begin
         last_d = sel_m1;
      end
   end

   // Last-grant register; reset to m1-last so m0 goes first
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Fixed priority: m0 wins whenever it requests, so m1 can be starved
   always_comb begin
      sel_m1 = ~m0_req_i;
   end
`endif

   assign fifo_full  = (count_q == FULL_CNT);
   assign fifo_empty = (count_q == '0);
   assign head_id    = id_mem_q[rd_ptr_q];

   // Mux the selected master's payload onto the slave bus, zero when idle
   always_comb begin
      sel_req    = m0_req_i | m1_req_i;
      s_we_o     = 1'b0;
      s_addr_bo  = '0;
      s_be_bo    = '0;
      s_wdata_bo = '0;
      if (sel_req) begin
         if (sel_m1) begin
            s_we_o     = m1_we_i;
            s_addr_bo  = m1_addr_bi;
            s_be_bo    = m1_be_bi;
            s_wdata_bo = m1_wdata_bi;
         end else begin
            s_we_o     = m0_we_i;
            s_addr_bo  = m0_addr_bi;
            s_be_bo    = m0_be_bi;
            s_wdata_bo = m0_wdata_bi;
         end
      end
   end

   // A read is held off only when no ID slot is free and none frees up this cycle
   always_comb begin
      blk      = sel_req & ~s_we_o & fifo_full & ~s_resp_i;
      s_req_o  = sel_req & ~blk & ~rst_i;
      m0_ack_o = s_ack_i & s_req_o & ~sel_m1;
      m1_ack_o = s_ack_i & s_req_o & sel_m1;
      push     = s_req_o & s_ack_i & ~s_we_o;
      pop      = s_resp_i & ~fifo_empty;
      spurious = s_resp_i & fifo_empty;
   end

   // ID FIFO next state: record owner on accepted reads, retire on each response
   always_comb begin
      id_mem_d = id_mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         id_mem_d[wr_ptr_q] = sel_m1;
         wr_ptr_d           = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Steer the response to the FIFO head owner; responses with no owner raise err
   always_comb begin
      m0_resp_d  = pop & ~head_id;
      m1_resp_d  = pop & head_id;
      m0_rdata_d = m0_resp_d ? s_rdata_bi : '0;
      m1_rdata_d = m1_resp_d ? s_rdata_bi : '0;
      err_d      = err_q | spurious;
   end

   // State registers; reset empties the FIFO and discards outstanding reads
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         id_mem_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         m0_resp_q  <= 1'b0;
         m1_resp_q  <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
         err_q      <= 1'b0;
      end else begin
         id_mem_q   <= id_mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         m0_resp_q  <= m0_resp_d;
         m1_resp_q  <= m1_resp_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
         err_q      <= err_d;
      end
   end

   assign m0_resp_o   = m0_resp_q;
   assign m1_resp_o   = m1_resp_q;
   assign m0_rdata_bo = m0_rdata_q;
   assign m1_rdata_bo = m1_rdata_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_udm_bus_arbiter.sv
// tb_udm_bus_arbiter: directed test of udm_bus_arbiter against a queue-based
// behavioural model, plus hand-computed literal expectations.

module tb_udm_bus_arbiter;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BW    = DW / 8;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          m0_req_i, m0_we_i, m0_ack_o, m0_resp_o;
   logic [AW-1:0] m0_addr_bi;
   logic [BW-1:0] m0_be_bi;
   logic [DW-1:0] m0_wdata_bi, m0_rdata_bo;
   logic          m1_req_i, m1_we_i, m1_ack_o, m1_resp_o;
   logic [AW-1:0] m1_addr_bi;
   logic [BW-1:0] m1_be_bi;
   logic [DW-1:0] m1_wdata_bi, m1_rdata_bo;
   logic          s_req_o, s_we_o, s_ack_i, s_resp_i, err_o;
   logic [AW-1:0] s_addr_bo;
   logic [BW-1:0] s_be_bo;
   logic [DW-1:0] s_wdata_bo, s_rdata_bi;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Free-running clock
   always #5 clk_i = ~clk_i;

   udm_bus_arbiter #(.OUTST_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi),
      .m0_be_bi(m0_be_bi), .m0_wdata_bi(m0_wdata_bi), .m0_ack_o(m0_ack_o),
      .m0_resp_o(m0_resp_o), .m0_rdata_bo(m0_rdata_bo),
      .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi),
      .m1_be_bi(m1_be_bi), .m1_wdata_bi(m1_wdata_bi), .m1_ack_o(m1_ack_o),
      .m1_resp_o(m1_resp_o), .m1_rdata_bo(m1_rdata_bo),
      .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo),
      .s_be_bo(s_be_bo), .s_wdata_bo(s_wdata_bo), .s_ack_i(s_ack_i),
      .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi), .err_o(err_o)
   );

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge, return at the falling edge
   task automatic apply_stimulus(input logic rst,
                                 input logic r0, input logic w0, input logic [AW-1:0] a0,
                                 input logic r1, input logic w1, input logic [AW-1:0] a1,
                                 input logic sa, input logic sr, input logic [DW-1:0] rd);
      @(posedge clk_i);
      #1;
      rst_i       = rst;
      m0_req_i    = r0;
      m0_we_i     = w0;
      m0_addr_bi  = a0;
      m0_be_bi    = 4'hF;
      m0_wdata_bi = a0 ^ 32'h0F0F_0000;
      m1_req_i    = r1;
      m1_we_i     = w1;
      m1_addr_bi  = a1;
      m1_be_bi    = 4'h3;
      m1_wdata_bi = a1 ^ 32'h1111_1111;
      s_ack_i     = sa;
      s_resp_i    = sr;
      s_rdata_bi  = rd;
      @(negedge clk_i);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic slave_resp(input logic [DW-1:0] rd);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, rd);
   endtask

   // Behavioural model: owners of outstanding reads kept in a plain queue
   int            owner_q[$];
   int            last_grant = 1;
   logic          exp_resp0  = 1'b0;
   logic          exp_resp1  = 1'b0;
   logic [DW-1:0] exp_rdata0 = '0;
   logic [DW-1:0] exp_rdata1 = '0;
   logic          exp_err    = 1'b0;

   // Compare every cycle at the falling edge, then advance the model to the next cycle
   initial begin
      int            win, head;
      logic          any, we, blocked, ereq, acc;
      logic [AW-1:0] ea;
      logic [BW-1:0] eb;
      logic [DW-1:0] ew;
      forever begin
         @(negedge clk_i);
         any = m0_req_i | m1_req_i;
         win = m0_req_i ? 0 : 1;
`ifdef UDM_ARB_RR_EN
         if (m0_req_i && m1_req_i) win = (last_grant == 0) ? 1 : 0;
`endif
         we = 1'b0; ea = '0; eb = '0; ew = '0;
         if (any) begin
            we = (win == 0) ? m0_we_i     : m1_we_i;
            ea = (win == 0) ? m0_addr_bi  : m1_addr_bi;
            eb = (win == 0) ? m0_be_bi    : m1_be_bi;
            ew = (win == 0) ? m0_wdata_bi : m1_wdata_bi;
         end
         blocked = any && !we && (owner_q.size() == DEPTH) && !s_resp_i;
         ereq    = any && !blocked && !rst_i;
         acc     = ereq && s_ack_i;

         check_output("s_req",    s_req_o,     ereq);
         check_output("s_we",     s_we_o,      we);
         check_output("s_addr",   s_addr_bo,   ea);
         check_output("s_be",     s_be_bo,     eb);
         check_output("s_wdata",  s_wdata_bo,  ew);
         check_output("m0_ack",   m0_ack_o,    acc && win == 0);
         check_output("m1_ack",   m1_ack_o,    acc && win == 1);
         check_output("m0_resp",  m0_resp_o,   exp_resp0);
         check_output("m0_rdata", m0_rdata_bo, exp_rdata0);
         check_output("m1_resp",  m1_resp_o,   exp_resp1);
         check_output("m1_rdata", m1_rdata_bo, exp_rdata1);
         check_output("err",      err_o,       exp_err);

         exp_resp0 = 1'b0; exp_resp1 = 1'b0; exp_rdata0 = '0; exp_rdata1 = '0;
         if (rst_i) begin
            owner_q.delete();
            last_grant = 1;
            exp_err    = 1'b0;
         end else begin
            if (s_resp_i) begin
               if (owner_q.size() == 0) begin
                  exp_err = 1'b1;
               end else begin
                  head = owner_q.pop_front();
                  if (head == 0) begin exp_resp0 = 1'b1; exp_rdata0 = s_rdata_bi; end
                  else           begin exp_resp1 = 1'b1; exp_rdata1 = s_rdata_bi; end
               end
            end
            if (acc) begin
               last_grant = win;
               if (!we) owner_q.push_back(win);
            end
         end
      end
   end

   // Directed scenarios with hand-computed literal expectations
   initial begin
      logic exp_m0;
      rst_i = 1'b1;
      m0_req_i = 0; m0_we_i = 0; m0_addr_bi = '0; m0_be_bi = '0; m0_wdata_bi = '0;
      m1_req_i = 0; m1_we_i = 0; m1_addr_bi = '0; m1_be_bi = '0; m1_wdata_bi = '0;
      s_ack_i = 0; s_resp_i = 0; s_rdata_bi = '0;

      apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply_stimulus(1, 1, 0, 32'h44, 0, 0, 0, 1, 0, 0);
      check_output("reset_s_req_forced", s_req_o, 0);
      check_output("reset_m0_ack_forced", m0_ack_o, 0);
      check_output("reset_err", err_o, 0);
      check_output("reset_m0_resp", m0_resp_o, 0);

      // Contention: both masters hold continuous writes
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(0, 1, 1, 32'h0, 1, 1, 32'h4, 1, 0, 0);
`ifdef UDM_ARB_RR_EN
         exp_m0 = (i % 2 == 0);
`else
         exp_m0 = 1'b1;
`endif
         check_output("contention_m0_ack", m0_ack_o, exp_m0);
         check_output("contention_m1_ack", m1_ack_o, !exp_m0);
      end
      idle(1);

      // Single read from m0, response two cycles after acceptance
      apply_stimulus(0, 1, 0, 32'h8000_0000, 0, 0, 0, 1, 0, 0);
      check_output("single_m0_ack", m0_ack_o, 1);
      check_output("single_s_addr", s_addr_bo, 32'h8000_0000);
      idle(1);
      check_output("single_m0_ack_pulse", m0_ack_o, 0);
      slave_resp(32'hDEAD_BEEF);
      idle(1);
      check_output("single_m0_resp", m0_resp_o, 1);
      check_output("single_m0_rdata", m0_rdata_bo, 32'hDEAD_BEEF);
      check_output("single_m1_resp", m1_resp_o, 0);
      idle(1);
      check_output("single_m0_rdata_clear", m0_rdata_bo, 0);

      // Interleaved reads: m1, m0, m1 then in-order responses 1, 2, 3
      apply_stimulus(0, 0, 0, 0, 1, 0, 32'h100, 1, 0, 0);
      apply_stimulus(0, 1, 0, 32'h200, 0, 0, 0, 1, 0, 0);
      apply_stimulus(0, 0, 0, 0, 1, 0, 32'h300, 1, 0, 0);
      slave_resp(32'd1);
      slave_resp(32'd2);
      check_output("interleave_m1_first", m1_rdata_bo, 32'd1);
      slave_resp(32'd3);
      check_output("interleave_m0_second", m0_rdata_bo, 32'd2);
      check_output("interleave_m1_idle", m1_resp_o, 0);
      idle(1);
      check_output("interleave_m1_third", m1_rdata_bo, 32'd3);

      // FIFO full: four reads outstanding, fifth blocked until a response frees a slot
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(0, 1, 0, 32'h10 * (i + 1), 0, 0, 0, 1, 0, 0);
         check_output("fill_m0_ack", m0_ack_o, 1);
      end
      apply_stimulus(0, 0, 0, 0, 1, 0, 32'h50, 1, 0, 0);
      check_output("full_s_req_blocked", s_req_o, 0);
      check_output("full_m1_ack_blocked", m1_ack_o, 0);
      apply_stimulus(0, 0, 0, 0, 1, 0, 32'h50, 1, 1, 32'hA1);
      check_output("full_pop_push_ack", m1_ack_o, 1);
      apply_stimulus(0, 1, 0, 32'h60, 0, 0, 0, 1, 0, 0);
      check_output("full_count_stays_4", s_req_o, 0);
      check_output("full_resp_a1", m0_rdata_bo, 32'hA1);
      apply_stimulus(0, 1, 0, 32'h60, 0, 0, 0, 1, 1, 32'hA2);
      check_output("full_pop_push_ack2", m0_ack_o, 1);
      slave_resp(32'hA3);
      check_output("drain_a2", m0_rdata_bo, 32'hA2);
      slave_resp(32'hA4);
      slave_resp(32'hA5);
      slave_resp(32'hA6);
      check_output("drain_m1_a5", m1_rdata_bo, 32'hA5);
      check_output("drain_m0_quiet", m0_resp_o, 0);
      idle(1);
      check_output("drain_a6", m0_rdata_bo, 32'hA6);

      // Spurious response with nothing outstanding
      slave_resp(32'h55);
      idle(1);
      check_output("spurious_err", err_o, 1);
      check_output("spurious_no_m0_resp", m0_resp_o, 0);
      check_output("spurious_no_m1_resp", m1_resp_o, 0);
      idle(3);
      check_output("spurious_err_sticky", err_o, 1);

      // Reset with two reads outstanding, then a fresh read and a late response
      apply_stimulus(0, 1, 0, 32'h700, 0, 0, 0, 1, 0, 0);
      apply_stimulus(0, 0, 0, 0, 1, 0, 32'h704, 1, 0, 0);
      apply_stimulus(1, 1, 0, 32'h900, 0, 0, 0, 1, 0, 0);
      check_output("midreset_s_req", s_req_o, 0);
      check_output("midreset_m0_ack", m0_ack_o, 0);
      idle(1);
      check_output("postreset_err_clear", err_o, 0);
      apply_stimulus(0, 1, 0, 32'h800, 0, 0, 0, 1, 0, 0);
      check_output("postreset_read_ack", m0_ack_o, 1);
      idle(1);
      slave_resp(32'h1234);
      idle(1);
      check_output("postreset_read_data", m0_rdata_bo, 32'h1234);
      slave_resp(32'hBAD);
      idle(1);
      check_output("late_resp_err", err_o, 1);
      check_output("late_resp_no_m0", m0_resp_o, 0);

      @(posedge clk_i);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
